// File: rtl/cdc_req_source.sv
// rtl/cdc_req_source.sv - launch side of a 4-phase req/ack CDC handshake
// Holds one word on cdc_data while cdc_req/ack complete a full four-phase cycle.
module cdc_req_source #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  cdc_req,
  output logic [DATA_WIDTH-1:0] cdc_data,
  input  logic                  cdc_ack,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  localparam bit                   LP_TMO_EN = (TIMEOUT > 0);
  localparam logic [CNT_WIDTH-1:0] LP_TMO    = CNT_WIDTH'(TIMEOUT);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_ack_sync;
  logic                    w_ack_s;
  logic                    r_req;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_change;
  logic                    w_hit;

  assign w_ack_s  = r_ack_sync[1];
  assign w_accept = (r_state == S_IDLE) && i_valid;
  assign w_change = (w_state_next != r_state);

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid)  w_state_next = S_REQ;
      S_REQ:   if (w_ack_s)  w_state_next = S_DROP;
      S_DROP:  if (!w_ack_s) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    i_ready = (r_state == S_IDLE);
    busy    = (r_state != S_IDLE);
  end

  // cdc_data loads only on an IDLE accept, so it is quiet for the whole handshake
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_ack_sync <= 2'b00;
      r_req      <= 1'b0;
      r_data     <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[0], cdc_ack};
      r_req      <= (w_state_next == S_REQ);
      if (w_accept) begin
        r_data <= i_data;
      end
    end
  end

  // Error fires only on the cycle the counter reaches the limit, so clr_err can clear it afterwards
  assign w_hit = LP_TMO_EN && busy && !w_change && (r_cnt == LP_TMO - 1'b1);

  always_ff @(posedge aclk) begin
    if (!arstn || !LP_TMO_EN) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_change) begin
        r_cnt <= '0;
      end else if (busy && (r_cnt != LP_TMO)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_hit) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign cdc_req     = r_req;
  assign cdc_data    = r_data;
  assign timeout_err = r_err;

endmodule
